// File: rtl/tl_ul_inflight_monitor.sv
// TileLink-UL in-flight monitor for one A/D channel pair.
// Checks per-beat legality, held-valid stability and per-source request/response
// pairing. Violations are reported one cycle after the offending edge as a pulse
// plus a 4-bit code (lowest code wins), and latched into a sticky flag.
// Optional per-source timeout checking is enabled by defining TL_UL_MONITOR_TIMEOUT_EN.
module tl_ul_inflight_monitor #(
  parameter int SOURCE_BITS    = 2,
  parameter int ADDR_BITS      = 32,
  parameter int DATA_BYTES     = 4,
  parameter int SIZE_BITS      = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   a_valid,
  input  logic                   a_ready,
  input  logic [2:0]             a_opcode,
  input  logic [SIZE_BITS-1:0]   a_size,
  input  logic [SOURCE_BITS-1:0] a_source,
  input  logic [ADDR_BITS-1:0]   a_address,
  input  logic [DATA_BYTES-1:0]  a_mask,
  input  logic                   d_valid,
  input  logic                   d_ready,
  input  logic [2:0]             d_opcode,
  input  logic [SIZE_BITS-1:0]   d_size,
  input  logic [SOURCE_BITS-1:0] d_source,
  input  logic                   d_denied,
  output logic                   err_pulse,
  output logic [3:0]             err_code,
  output logic                   err_sticky,
  output logic [SOURCE_BITS:0]   inflight_cnt
);

  localparam int NSRC       = 1 << SOURCE_BITS;
  localparam int LOG2_BYTES = $clog2(DATA_BYTES);

  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_GET         = 3'd4;
  localparam logic [2:0] OP_ACK         = 3'd0;
  localparam logic [2:0] OP_ACK_DATA    = 3'd1;

  logic a_fire, d_fire;
  assign a_fire = a_valid & a_ready;
  assign d_fire = d_valid & d_ready;

  // Per-source table
  logic [NSRC-1:0]      busy_q, busy_n;
  logic                 exp_data_q [NSRC];
  logic [SIZE_BITS-1:0] size_tab_q [NSRC];

  // Stability snapshots of the previous cycle's stalled beats
  logic                   a_hold_q;
  logic [2:0]             a_opcode_q;
  logic [SIZE_BITS-1:0]   a_size_q;
  logic [SOURCE_BITS-1:0] a_source_q;
  logic [ADDR_BITS-1:0]   a_address_q;
  logic [DATA_BYTES-1:0]  a_mask_q;
  logic                   d_hold_q;
  logic [2:0]             d_opcode_q;
  logic [SIZE_BITS-1:0]   d_size_q;
  logic [SOURCE_BITS-1:0] d_source_q;
  logic                   d_denied_q;

  logic op_bad, size_bad, addr_bad, mask_bad;
  logic a_unstable, d_unstable;
  logic a_dup, d_orphan, d_op_bad, d_size_bad;
  logic timeout_hit;
  logic a_set;
  logic is_put;
  logic mask_out;
  logic in_win;
  logic [3:0] code;

  // A-channel per-beat legality: opcode, size, alignment and lane window
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned, which would infer a latch.
    addr_bad = 1'b0;
    mask_out = 1'b0;
    in_win   = 1'b1;
    is_put   = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PARTIAL);
    op_bad   = a_valid && !(is_put || a_opcode == OP_GET);
    size_bad = a_valid && (int'(a_size) > LOG2_BYTES);
    for (int i = 0; i < ADDR_BITS; i++) begin
      if (i < int'(a_size) && a_address[i]) addr_bad = 1'b1;
    end
    addr_bad = a_valid && addr_bad;
    // A lane is in the window when its index matches the address in every bit at or above a_size.
    for (int j = 0; j < DATA_BYTES; j++) begin
      in_win = 1'b1;
      for (int b = 0; b < LOG2_BYTES; b++) begin
        if (b >= int'(a_size) && (((j >> b) & 1) != int'(a_address[b]))) in_win = 1'b0;
      end
      if (a_mask[j] && !in_win) mask_out = 1'b1;
    end
    mask_bad = a_valid && is_put && ((a_mask == '0) || mask_out);
  end

  // Held-valid stability and request/response pairing checks
  always_comb begin
    a_unstable = a_hold_q && (!a_valid || a_opcode != a_opcode_q || a_size != a_size_q ||
                              a_source != a_source_q || a_address != a_address_q ||
                              a_mask != a_mask_q);
    d_unstable = d_hold_q && (!d_valid || d_opcode != d_opcode_q || d_size != d_size_q ||
                              d_source != d_source_q || d_denied != d_denied_q);
    // A busy source may be reissued only if its response retires on the same edge.
    a_dup      = a_fire && busy_q[a_source] && !(d_fire && d_source == a_source);
    d_orphan   = d_fire && !busy_q[d_source];
    d_op_bad   = d_fire && (d_opcode != (exp_data_q[d_source] ? OP_ACK_DATA : OP_ACK));
    d_size_bad = d_fire && (d_size != size_tab_q[d_source]);
    a_set      = a_fire && !(op_bad || size_bad || addr_bad || mask_bad);
  end

  // Priority encode: lowest violation code wins
  always_comb begin
    code = 4'd0;
    if      (op_bad)      code = 4'd1;
    else if (size_bad)    code = 4'd2;
    else if (addr_bad)    code = 4'd3;
    else if (mask_bad)    code = 4'd4;
    else if (a_unstable)  code = 4'd5;
    else if (d_unstable)  code = 4'd6;
    else if (a_dup)       code = 4'd7;
    else if (d_orphan)    code = 4'd8;
    else if (d_op_bad)    code = 4'd9;
    else if (d_size_bad)  code = 4'd10;
    else if (timeout_hit) code = 4'd11;
  end

  // Next busy vector: retire first, then set, so same-source reuse nets to busy
  always_comb begin
    busy_n = busy_q;
    if (d_fire) busy_n[d_source] = 1'b0;
    if (a_set)  busy_n[a_source] = 1'b1;
  end

  // Busy bits, stability snapshots and error outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q      <= '0;
      a_hold_q    <= 1'b0;
      a_opcode_q  <= '0;
      a_size_q    <= '0;
      a_source_q  <= '0;
      a_address_q <= '0;
      a_mask_q    <= '0;
      d_hold_q    <= 1'b0;
      d_opcode_q  <= '0;
      d_size_q    <= '0;
      d_source_q  <= '0;
      d_denied_q  <= 1'b0;
      err_pulse   <= 1'b0;
      err_code    <= 4'd0;
      err_sticky  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      busy_q      <= busy_n;
      a_hold_q    <= a_valid & ~a_ready;
      a_opcode_q  <= a_opcode;
      a_size_q    <= a_size;
      a_source_q  <= a_source;
      a_address_q <= a_address;
      a_mask_q    <= a_mask;
      d_hold_q    <= d_valid & ~d_ready;
      d_opcode_q  <= d_opcode;
      d_size_q    <= d_size;
      d_source_q  <= d_source;
      d_denied_q  <= d_denied;
      err_pulse   <= (code != 4'd0);
      err_code    <= code;
      err_sticky  <= err_sticky | (code != 4'd0);
    end
  end

  // Record expected response opcode and size for each accepted request
  always_ff @(posedge clock) begin
    // NOTE: the payload table has no reset; entries are only read while busy, and busy is reset.
    if (a_set) begin
      exp_data_q[a_source] <= (a_opcode == OP_GET);
      size_tab_q[a_source] <= a_size;
    end
  end

  // Outstanding-source count
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < NSRC; i++) begin
      inflight_cnt = inflight_cnt + (SOURCE_BITS+1)'(busy_q[i]);
    end
  end

`ifdef TL_UL_MONITOR_TIMEOUT_EN
  localparam int AGE_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [AGE_W-1:0] age_q [NSRC];
  logic [NSRC-1:0]  hit_vec;

  // A source times out on the cycle its age would step onto TIMEOUT_CYCLES; saturation makes it once per transaction.
  always_comb begin
    for (int s = 0; s < NSRC; s++) begin
      hit_vec[s] = busy_q[s] && (age_q[s] == AGE_W'(TIMEOUT_CYCLES - 1)) &&
                   !(d_fire && int'(d_source) == s) && !(a_set && int'(a_source) == s);
    end
    timeout_hit = |hit_vec;
  end

  // Per-source age counters: zero on issue or retire, count while busy, saturate
  always_ff @(posedge clock) begin
    for (int s = 0; s < NSRC; s++) begin
      if (reset) begin
        age_q[s] <= '0;
      end else if ((a_set && int'(a_source) == s) || (d_fire && int'(d_source) == s)) begin
        age_q[s] <= '0;
      end else if (busy_q[s] && age_q[s] != AGE_W'(TIMEOUT_CYCLES)) begin
        age_q[s] <= age_q[s] + 1'b1;
      end
    end
  end
`else
  // Timeout checking compiled out; never true for any legal TIMEOUT_CYCLES.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_tl_ul_inflight_monitor.sv
// Directed testbench for tl_ul_inflight_monitor (default build; the timeout
// scenario runs only when TL_UL_MONITOR_TIMEOUT_EN is defined).
module tb_tl_ul_inflight_monitor;

  localparam int SB = 2;
  localparam int AB = 32;
  localparam int DB = 4;
  localparam int ZB = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          a_valid, a_ready;
  logic [2:0]    a_opcode;
  logic [ZB-1:0] a_size;
  logic [SB-1:0] a_source;
  logic [AB-1:0] a_address;
  logic [DB-1:0] a_mask;
  logic          d_valid, d_ready;
  logic [2:0]    d_opcode;
  logic [ZB-1:0] d_size;
  logic [SB-1:0] d_source;
  logic          d_denied;
  logic          err_pulse;
  logic [3:0]    err_code;
  logic          err_sticky;
  logic [SB:0]   inflight_cnt;

  int errors = 0;
  int checks = 0;

  tl_ul_inflight_monitor #(
    .SOURCE_BITS(SB), .ADDR_BITS(AB), .DATA_BYTES(DB), .SIZE_BITS(ZB), .TIMEOUT_CYCLES(16)
  ) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
    .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
    .d_source(d_source), .d_denied(d_denied),
    .err_pulse(err_pulse), .err_code(err_code), .err_sticky(err_sticky),
    .inflight_cnt(inflight_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just past the edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic a_drive(input logic v, input logic r, input logic [2:0] op, input logic [ZB-1:0] sz,
                         input logic [SB-1:0] src, input logic [AB-1:0] addr, input logic [DB-1:0] m);
    a_valid = v; a_ready = r; a_opcode = op; a_size = sz;
    a_source = src; a_address = addr; a_mask = m;
  endtask

  task automatic d_drive(input logic v, input logic r, input logic [2:0] op, input logic [ZB-1:0] sz,
                         input logic [SB-1:0] src);
    d_valid = v; d_ready = r; d_opcode = op; d_size = sz; d_source = src; d_denied = 1'b0;
  endtask

  task automatic idle();
    a_drive(1'b0, 1'b0, 3'd0, '0, '0, '0, '0);
    d_drive(1'b0, 1'b0, 3'd0, '0, '0);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick(); tick();
    check("rst_pulse",   32'(err_pulse), 0);
    check("rst_code",    32'(err_code), 0);
    check("rst_sticky",  32'(err_sticky), 0);
    check("rst_inflight", 32'(inflight_cnt), 0);
    reset = 1'b0;
    tick();

    // Clean Get / AccessAckData on source 1
    a_drive(1, 1, 3'd4, 2'd2, 2'd1, 32'h100, 4'hF);
    tick(); check("get1_code", 32'(err_code), 0); check("get1_cnt", 32'(inflight_cnt), 1);
    idle(); tick(); tick();
    d_drive(1, 1, 3'd1, 2'd2, 2'd1);
    tick(); check("ack1_code", 32'(err_code), 0); check("ack1_cnt", 32'(inflight_cnt), 0);
    idle(); tick();
    check("ack1_pulse", 32'(err_pulse), 0); check("ack1_sticky", 32'(err_sticky), 0);

    // Misaligned PutFull -> code 3, no busy bit, later D -> code 8
    a_drive(1, 1, 3'd0, 2'd2, 2'd2, 32'h102, 4'hF);
    tick(); check("mis_code", 32'(err_code), 3); check("mis_pulse", 32'(err_pulse), 1);
    check("mis_sticky", 32'(err_sticky), 1); check("mis_cnt", 32'(inflight_cnt), 0);
    idle(); tick(); check("mis_pulse_end", 32'(err_pulse), 0); check("mis_sticky_hold", 32'(err_sticky), 1);
    d_drive(1, 1, 3'd0, 2'd2, 2'd2);
    tick(); check("orphan_code", 32'(err_code), 8);
    idle(); tick();

    // Get answered with AccessAck -> code 9, busy cleared
    a_drive(1, 1, 3'd4, 2'd2, 2'd0, 32'h0, 4'hF);
    tick(); check("get0_cnt", 32'(inflight_cnt), 1);
    idle(); d_drive(1, 1, 3'd0, 2'd2, 2'd0);
    tick(); check("badop_code", 32'(err_code), 9); check("badop_cnt", 32'(inflight_cnt), 0);
    idle(); tick();

    // Stalled A beat changes address -> code 5
    a_drive(1, 0, 3'd4, 2'd2, 2'd0, 32'h200, 4'hF);
    tick(); check("astab_hold", 32'(err_code), 0);
    a_drive(1, 0, 3'd4, 2'd2, 2'd0, 32'h204, 4'hF);
    tick(); check("astab_code", 32'(err_code), 5);
    a_drive(1, 1, 3'd4, 2'd2, 2'd0, 32'h204, 4'hF);
    tick(); check("astab_accept", 32'(err_code), 0); check("astab_cnt", 32'(inflight_cnt), 1);
    idle(); d_drive(1, 1, 3'd1, 2'd2, 2'd0);
    tick(); check("astab_ret", 32'(err_code), 0); check("astab_cnt0", 32'(inflight_cnt), 0);
    idle(); tick();

    // Same-edge retire and reissue on source 3
    a_drive(1, 1, 3'd4, 2'd2, 2'd3, 32'h300, 4'hF);
    tick(); check("reuse_cnt1", 32'(inflight_cnt), 1);
    idle(); tick();
    a_drive(1, 1, 3'd4, 2'd2, 2'd3, 32'h304, 4'hF); d_drive(1, 1, 3'd1, 2'd2, 2'd3);
    tick(); check("reuse_code", 32'(err_code), 0); check("reuse_cnt", 32'(inflight_cnt), 1);
    idle(); tick(); check("reuse_pulse", 32'(err_pulse), 0);
    d_drive(1, 1, 3'd1, 2'd2, 2'd3);
    tick(); check("reuse_ret_cnt", 32'(inflight_cnt), 0);
    idle(); tick();

    // Beat legality: opcode (wins over size), size, lane window, empty mask
    a_drive(1, 1, 3'd2, 2'd3, 2'd0, 32'h0, 4'hF);
    tick(); check("opc_code", 32'(err_code), 1); check("opc_cnt", 32'(inflight_cnt), 0);
    a_drive(1, 1, 3'd4, 2'd3, 2'd0, 32'h0, 4'hF);
    tick(); check("size_code", 32'(err_code), 2);
    a_drive(1, 1, 3'd1, 2'd0, 2'd0, 32'h0, 4'h2);
    tick(); check("lane_code", 32'(err_code), 4);
    a_drive(1, 1, 3'd0, 2'd2, 2'd0, 32'h10, 4'h0);
    tick(); check("mask0_code", 32'(err_code), 4); check("mask0_cnt", 32'(inflight_cnt), 0);
    idle(); tick(); check("legal_clear", 32'(err_code), 0);

    // Stalled D beat changes opcode, then drops valid -> code 6 twice
    d_drive(1, 0, 3'd1, 2'd2, 2'd0);
    tick(); check("dstab_hold", 32'(err_code), 0);
    d_drive(1, 0, 3'd0, 2'd2, 2'd0);
    tick(); check("dstab_chg", 32'(err_code), 6);
    idle();
    tick(); check("dstab_drop", 32'(err_code), 6);
    tick(); check("dstab_idle", 32'(err_code), 0);

    // Reissue to a busy source -> code 7
    a_drive(1, 1, 3'd4, 2'd2, 2'd1, 32'h40, 4'hF);
    tick(); check("dup_first", 32'(err_code), 0);
    tick(); check("dup_code", 32'(err_code), 7); check("dup_cnt", 32'(inflight_cnt), 1);
    idle(); d_drive(1, 1, 3'd1, 2'd2, 2'd1);
    tick(); check("dup_ret", 32'(err_code), 0); check("dup_cnt0", 32'(inflight_cnt), 0);
    idle(); tick();

    // Size mismatch on the response -> code 10, busy cleared
    a_drive(1, 1, 3'd4, 2'd1, 2'd2, 32'h2, 4'hC);
    tick(); check("sz_req", 32'(err_code), 0); check("sz_cnt", 32'(inflight_cnt), 1);
    idle(); d_drive(1, 1, 3'd1, 2'd2, 2'd2);
    tick(); check("sz_code", 32'(err_code), 10); check("sz_cnt0", 32'(inflight_cnt), 0);
    idle(); tick();

`ifdef TL_UL_MONITOR_TIMEOUT_EN
    // Timeout: single code 11 after 16 busy cycles, silent retire afterwards
    begin
      int pulses;
      pulses = 0;
      a_drive(1, 1, 3'd4, 2'd2, 2'd1, 32'h80, 4'hF);
      tick(); idle();
      for (int k = 0; k < 15; k++) begin
        tick();
        if (err_pulse) pulses++;
      end
      check("to_early", 32'(pulses), 0);
      tick(); check("to_code", 32'(err_code), 11);
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
        tick();
        if (err_pulse) pulses++;
      end
      check("to_once", 32'(pulses), 0);
      d_drive(1, 1, 3'd1, 2'd2, 2'd1);
      tick(); check("to_ret", 32'(err_code), 0); check("to_cnt", 32'(inflight_cnt), 0);
      idle(); tick();
    end
`endif

    // Reset mid-transaction clears the table; the late D is an orphan
    a_drive(1, 1, 3'd4, 2'd2, 2'd1, 32'h100, 4'hF);
    tick(); check("mid_cnt", 32'(inflight_cnt), 1);
    idle(); reset = 1'b1;
    tick(); check("mid_rst_cnt", 32'(inflight_cnt), 0); check("mid_rst_sticky", 32'(err_sticky), 0);
    reset = 1'b0;
    d_drive(1, 1, 3'd1, 2'd2, 2'd1);
    tick(); check("mid_orphan", 32'(err_code), 8); check("mid_sticky", 32'(err_sticky), 1);
    idle(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
